// File: rtl/rst_seq_ctrl.sv
// PLL-lock monitor and staged reset sequencer in the clk_50m domain.
// Releases N_DOM domain resets one at a time once the unmasked PLL locks have been stable for LOCK_STABLE cycles.
module rst_seq_ctrl #(
  parameter int N_PLL       = 3,
  parameter int N_DOM       = 4,
  parameter int LOCK_STABLE = 1024,
  parameter int STAGE_GAP   = 16,
  parameter int HOLD_CYCLES = 256,
  parameter int CNT_W       = 8
) (
  input  logic             clk_50m,
  input  logic             glb_rst_n,
  input  logic [N_PLL-1:0] i_pll_lock,
  input  logic [N_PLL-1:0] i_lock_mask,
  input  logic             i_soft_rst,
  input  logic             i_fault_clr,
  output logic [N_DOM-1:0] o_dom_rst_n,
  output logic             o_all_rst_n,
  output logic [N_PLL-1:0] o_lock_sync,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_loss_cnt,
  output logic             o_fault
);

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_STABLE    = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  // One timer is shared by the stable, stage-gap and hold phases; it is sized for the longest one.
  localparam int CNT_MAX_A = (LOCK_STABLE > STAGE_GAP) ? LOCK_STABLE : STAGE_GAP;
  localparam int CNT_MAX   = (CNT_MAX_A > HOLD_CYCLES) ? CNT_MAX_A : HOLD_CYCLES;
  localparam int TW        = $clog2(CNT_MAX);
  localparam int IW        = (N_DOM > 1) ? $clog2(N_DOM) : 1;

  localparam logic [TW-1:0]    STABLE_LAST = TW'(LOCK_STABLE - 1);
  localparam logic [TW-1:0]    GAP_LAST    = TW'(STAGE_GAP - 1);
  localparam logic [TW-1:0]    HOLD_LAST   = TW'(HOLD_CYCLES - 1);
  localparam logic [IW-1:0]    IDX_LAST    = IW'(N_DOM - 1);
  localparam logic [CNT_W-1:0] LOSS_MAX    = '1;

  state_t           state;
  logic [TW-1:0]    tmr;
  logic [IW-1:0]    idx;
  logic [N_PLL-1:0] lock_meta;
  logic             elock;

  assign o_state = state;
  // The mask bypasses the synchroniser, so masking a dropped lock in time hides the loss.
  assign elock   = &(o_lock_sync | i_lock_mask);

  always_ff @(posedge clk_50m) begin
    if (!glb_rst_n) begin
      state       <= ST_WAIT_LOCK;
      tmr         <= '0;
      idx         <= '0;
      lock_meta   <= '0;
      o_lock_sync <= '0;
      o_dom_rst_n <= '0;
      o_all_rst_n <= 1'b0;
      o_loss_cnt  <= '0;
      o_fault     <= 1'b0;
    end else begin
      lock_meta   <= i_pll_lock;
      o_lock_sync <= lock_meta;
      // A loss later in this block overrides the clear.
      if (i_fault_clr) o_fault <= 1'b0;

      case (state)
        ST_WAIT_LOCK: begin
          if (elock && !i_soft_rst) begin
            state <= ST_STABLE;
            tmr   <= '0;
          end
        end

        ST_STABLE: begin
          if (i_soft_rst) begin
            state <= ST_FAULT;
            tmr   <= '0;
          end else if (!elock) begin
            state <= ST_WAIT_LOCK;
          end else if (tmr == STABLE_LAST) begin
            state <= ST_RELEASE;
            tmr   <= '0;
            idx   <= '0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        ST_RELEASE, ST_RUN: begin
          if (!elock || i_soft_rst) begin
            state       <= ST_FAULT;
            tmr         <= '0;
            o_dom_rst_n <= '0;
            o_all_rst_n <= 1'b0;
            if (!elock) begin
              o_fault <= 1'b1;
              if (o_loss_cnt != LOSS_MAX) o_loss_cnt <= o_loss_cnt + 1'b1;
            end
          end else if (state == ST_RELEASE) begin
            if (tmr == GAP_LAST) begin
              o_dom_rst_n[idx] <= 1'b1;
              tmr              <= '0;
              if (idx == IDX_LAST) begin
                state       <= ST_RUN;
                o_all_rst_n <= 1'b1;
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              tmr <= tmr + 1'b1;
            end
          end
        end

        ST_FAULT: begin
          if (i_soft_rst) begin
            tmr <= '0;
          end else if (tmr == HOLD_LAST) begin
            state <= ST_WAIT_LOCK;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        default: state <= ST_WAIT_LOCK;
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: power-up timing, glitch, loss, mask, soft reset, saturation, mid-release reset.
module tb_rst_seq_ctrl;

  logic       clk_50m;
  logic       glb_rst_n;
  logic [2:0] i_pll_lock;
  logic [2:0] i_lock_mask;
  logic       i_soft_rst;
  logic       i_fault_clr;
  logic [2:0] o_dom_rst_n;
  logic       o_all_rst_n;
  logic [2:0] o_lock_sync;
  logic [2:0] o_state;
  logic [1:0] o_loss_cnt;
  logic       o_fault;

  int total = 0;
  int bad   = 0;

  rst_seq_ctrl #(
    .N_PLL(3), .N_DOM(3), .LOCK_STABLE(8), .STAGE_GAP(4), .HOLD_CYCLES(6), .CNT_W(2)
  ) dut (
    .clk_50m    (clk_50m),
    .glb_rst_n  (glb_rst_n),
    .i_pll_lock (i_pll_lock),
    .i_lock_mask(i_lock_mask),
    .i_soft_rst (i_soft_rst),
    .i_fault_clr(i_fault_clr),
    .o_dom_rst_n(o_dom_rst_n),
    .o_all_rst_n(o_all_rst_n),
    .o_lock_sync(o_lock_sync),
    .o_state    (o_state),
    .o_loss_cnt (o_loss_cnt),
    .o_fault    (o_fault)
  );

  initial clk_50m = 1'b0;
  always #5 clk_50m = ~clk_50m;

  task automatic tick();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_state(input string tag, input logic [2:0] exp, input int budget);
    int n;
    n = 0;
    while (o_state !== exp && n < budget) begin
      tick();
      n++;
    end
    check(tag, {29'd0, o_state}, {29'd0, exp});
  endtask

  // Drop lock[2] from RUN, optionally pulsing i_fault_clr on the loss edge, then re-sequence.
  task automatic lose_lock(input string tag, input logic clr_on_set,
                           input logic [1:0] exp_cnt);
    i_pll_lock = 3'b011;
    ticks(2);
    if (clr_on_set) i_fault_clr = 1'b1;
    tick();
    i_fault_clr = 1'b0;
    check({tag, "_state"}, {29'd0, o_state}, 32'd4);
    check({tag, "_cnt"}, {30'd0, o_loss_cnt}, {30'd0, exp_cnt});
    check({tag, "_fault"}, {31'd0, o_fault}, 32'd1);
    i_pll_lock = 3'b111;
    wait_state({tag, "_rerun"}, 3'd3, 80);
  endtask

  initial begin
    int n;
    glb_rst_n   = 1'b0;
    i_pll_lock  = 3'b000;
    i_lock_mask = 3'b000;
    i_soft_rst  = 1'b0;
    i_fault_clr = 1'b0;

    // Power-up
    ticks(5);
    check("rst_state", {29'd0, o_state}, 32'd0);
    check("rst_dom", {29'd0, o_dom_rst_n}, 32'd0);
    check("rst_all", {31'd0, o_all_rst_n}, 32'd0);
    check("rst_sync", {29'd0, o_lock_sync}, 32'd0);
    check("rst_cnt", {30'd0, o_loss_cnt}, 32'd0);
    check("rst_fault", {31'd0, o_fault}, 32'd0);
    glb_rst_n  = 1'b1;
    i_pll_lock = 3'b111;
    tick();  // E0
    check("e0_sync", {29'd0, o_lock_sync}, 32'd0);
    tick();  // E1
    check("e1_sync", {29'd0, o_lock_sync}, 32'h7);
    check("e1_state", {29'd0, o_state}, 32'd0);
    tick();  // E2
    check("e2_state", {29'd0, o_state}, 32'd1);
    ticks(7);  // E9
    check("e9_state", {29'd0, o_state}, 32'd1);
    tick();  // E10
    check("e10_state", {29'd0, o_state}, 32'd2);
    ticks(3);  // E13
    check("e13_dom", {29'd0, o_dom_rst_n}, 32'h0);
    tick();  // E14
    check("e14_dom", {29'd0, o_dom_rst_n}, 32'h1);
    ticks(3);  // E17
    check("e17_dom", {29'd0, o_dom_rst_n}, 32'h1);
    tick();  // E18
    check("e18_dom", {29'd0, o_dom_rst_n}, 32'h3);
    ticks(3);  // E21
    check("e21_all", {31'd0, o_all_rst_n}, 32'd0);
    check("e21_state", {29'd0, o_state}, 32'd2);
    tick();  // E22
    check("e22_dom", {29'd0, o_dom_rst_n}, 32'h7);
    check("e22_all", {31'd0, o_all_rst_n}, 32'd1);
    check("e22_state", {29'd0, o_state}, 32'd3);
    ticks(2);
    check("run_steady", {29'd0, o_state}, 32'd3);

    // Soft reset held 10 cycles in RUN
    i_soft_rst = 1'b1;
    tick();  // S0
    check("soft_state", {29'd0, o_state}, 32'd4);
    check("soft_dom", {29'd0, o_dom_rst_n}, 32'h0);
    check("soft_all", {31'd0, o_all_rst_n}, 32'd0);
    ticks(9);  // S9
    i_soft_rst = 1'b0;
    check("soft_s9", {29'd0, o_state}, 32'd4);
    ticks(5);  // S14
    check("soft_s14", {29'd0, o_state}, 32'd4);
    tick();  // S15
    check("soft_s15", {29'd0, o_state}, 32'd0);
    check("soft_cnt", {30'd0, o_loss_cnt}, 32'd0);
    check("soft_fault", {31'd0, o_fault}, 32'd0);
    tick();  // S16
    check("soft_s16", {29'd0, o_state}, 32'd1);

    // Glitch on lock[1] seen while the stable counter is at 5
    ticks(3);  // S19
    i_pll_lock = 3'b101;
    tick();  // S20
    i_pll_lock = 3'b111;
    tick();  // S21
    check("glitch_sync", {29'd0, o_lock_sync}, 32'h5);
    check("glitch_s21", {29'd0, o_state}, 32'd1);
    tick();  // S22
    check("glitch_wait", {29'd0, o_state}, 32'd0);
    tick();  // S23
    check("glitch_restart", {29'd0, o_state}, 32'd1);
    ticks(7);  // S30
    check("glitch_s30", {29'd0, o_state}, 32'd1);
    tick();  // S31
    check("glitch_rel", {29'd0, o_state}, 32'd2);
    check("glitch_cnt", {30'd0, o_loss_cnt}, 32'd0);
    check("glitch_fault", {31'd0, o_fault}, 32'd0);
    wait_state("glitch_run", 3'd3, 40);

    // Loss in RUN
    i_pll_lock = 3'b011;
    tick();  // L0
    check("loss_l0", {29'd0, o_state}, 32'd3);
    tick();  // L1
    check("loss_l1_sync", {29'd0, o_lock_sync}, 32'h3);
    check("loss_l1_dom", {29'd0, o_dom_rst_n}, 32'h7);
    tick();  // L2 = F
    check("loss_state", {29'd0, o_state}, 32'd4);
    check("loss_dom", {29'd0, o_dom_rst_n}, 32'h0);
    check("loss_all", {31'd0, o_all_rst_n}, 32'd0);
    check("loss_cnt", {30'd0, o_loss_cnt}, 32'd1);
    check("loss_fault", {31'd0, o_fault}, 32'd1);
    ticks(5);
    check("hold_f5", {29'd0, o_state}, 32'd4);
    tick();
    check("hold_f6", {29'd0, o_state}, 32'd0);
    tick();
    check("hold_nolock", {29'd0, o_state}, 32'd0);
    i_pll_lock = 3'b111;
    wait_state("loss_rerun", 3'd3, 60);
    check("loss_rerun_all", {31'd0, o_all_rst_n}, 32'd1);

    // Masked loss
    i_lock_mask = 3'b100;
    i_pll_lock  = 3'b011;
    ticks(6);
    check("mask_state", {29'd0, o_state}, 32'd3);
    check("mask_sync", {29'd0, o_lock_sync}, 32'h3);
    check("mask_cnt", {30'd0, o_loss_cnt}, 32'd1);
    check("mask_all", {31'd0, o_all_rst_n}, 32'd1);
    i_pll_lock = 3'b111;
    ticks(3);
    i_lock_mask = 3'b000;
    ticks(2);
    check("unmask_state", {29'd0, o_state}, 32'd3);

    // Fault clear, clear-vs-set priority and counter saturation
    i_fault_clr = 1'b1;
    tick();
    i_fault_clr = 1'b0;
    check("clr_fault", {31'd0, o_fault}, 32'd0);
    lose_lock("loss2", 1'b0, 2'd2);
    i_fault_clr = 1'b1;
    tick();
    i_fault_clr = 1'b0;
    check("clr_fault2", {31'd0, o_fault}, 32'd0);
    lose_lock("loss3_clr", 1'b1, 2'd3);
    lose_lock("loss4_sat", 1'b0, 2'd3);

    // Reset mid-RELEASE
    i_soft_rst = 1'b1;
    tick();
    i_soft_rst = 1'b0;
    wait_state("mid_rel", 3'd2, 60);
    n = 0;
    while (o_dom_rst_n[0] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("mid_dom0", {29'd0, o_dom_rst_n}, 32'h1);
    glb_rst_n = 1'b0;
    tick();
    check("mid_rst_state", {29'd0, o_state}, 32'd0);
    check("mid_rst_dom", {29'd0, o_dom_rst_n}, 32'h0);
    check("mid_rst_sync", {29'd0, o_lock_sync}, 32'h0);
    check("mid_rst_cnt", {30'd0, o_loss_cnt}, 32'd0);
    check("mid_rst_fault", {31'd0, o_fault}, 32'd0);
    glb_rst_n = 1'b1;
    ticks(2);
    check("mid_e1_state", {29'd0, o_state}, 32'd0);
    check("mid_e1_sync", {29'd0, o_lock_sync}, 32'h7);
    tick();
    check("mid_e2_state", {29'd0, o_state}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
